// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads imem at pc, queues {pc, word} for decode.
// One outstanding request; flush drops the queue and any in-flight read.
module instr_fetch_unit #(
    parameter int ADDR_W  = 19,
    parameter int INSTR_W = 19,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_enable,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + INSTR_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_ADV   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  head;
    logic              full;
    logic              push;
    logic              pop;

    assign full        = (count_q == FULL_CNT);
    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid & instr_ready & ~flush;
    assign imem_req    = (state_q == S_REQ) | (state_q == S_DRAIN);
    assign imem_addr   = addr_q;
    assign pc_enable   = (state_q == S_ADV) & ~flush;

    // Head is gated so the outputs read zero while the queue is empty.
    assign head     = mem_q[rd_ptr_q];
    assign instr    = instr_valid ? head[INSTR_W-1:0] : '0;
    assign instr_pc = instr_valid ? head[ENT_W-1:INSTR_W] : '0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!full && !flush) begin
                    addr_d  = pc;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (flush) begin
                    state_d = imem_ack ? S_IDLE : S_DRAIN;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    state_d = S_ADV;
                end
            end
            S_ADV: state_d = S_IDLE;
            S_DRAIN: begin
                if (imem_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {addr_q, imem_rdata};
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a simple PC model.
// Inputs and checks happen on the falling edge.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] pc = '0;
    logic        pc_enable;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [18:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [18:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [18:0] instr;
    logic [18:0] instr_pc;

    logic [18:0] tgt = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          pcen_n = 0;
    int          pcen_ref;

    instr_fetch_unit #(.ADDR_W(19), .INSTR_W(19), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_enable  (pc_enable),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .instr_pc   (instr_pc)
    );

    always #5 clk = ~clk;

    // Program counter: redirect wins over sequential step; held in reset.
    always @(posedge clk) begin
        if (!rst) begin
            if (flush) pc <= tgt;
            else if (pc_enable) pc <= pc + 19'd1;
            if (pc_enable) pcen_n <= pcen_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".req"}, 32'(imem_req), 32'd0);
        chk({tag, ".pcen"}, 32'(pc_enable), 32'd0);
        chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    endtask

    initial begin
        // 1: reset
        step();
        chk_idle_outs("rst1");
        chk("rst1.addr", 32'(imem_addr), 32'd0);
        chk("rst1.instr", 32'(instr), 32'd0);
        chk("rst1.ipc", 32'(instr_pc), 32'd0);
        step();
        chk_idle_outs("rst2");
        rst = 1'b0;
        chk("post_rst.idle_req", 32'(imem_req), 32'd0);
        step();
        chk("first.req", 32'(imem_req), 32'd1);
        chk("first.addr", 32'(imem_addr), 32'd0);

        // 2: single fetch, ack one cycle after req rises
        step();
        chk("sf.req_held", 32'(imem_req), 32'd1);
        imem_ack = 1'b1;
        imem_rdata = 19'h12345;
        step();
        imem_ack = 1'b0;
        chk("sf.pcen", 32'(pc_enable), 32'd1);
        chk("sf.valid", 32'(instr_valid), 32'd1);
        chk("sf.instr", 32'(instr), 32'h12345);
        chk("sf.ipc", 32'(instr_pc), 32'd0);
        chk("sf.req_drop", 32'(imem_req), 32'd0);
        step();
        chk("sf.pcen_one", 32'(pc_enable), 32'd0);
        step();
        chk("sf.next_req", 32'(imem_req), 32'd1);
        chk("sf.next_addr", 32'(imem_addr), 32'd1);

        // 3: backpressure fills the queue with addr 0..3
        for (int a = 1; a <= 3; a++) begin
            chk("bp.addr", 32'(imem_addr), 32'(a));
            imem_ack = 1'b1;
            imem_rdata = 19'h100 + 19'(a);
            step();
            imem_ack = 1'b0;
            chk("bp.pcen", 32'(pc_enable), 32'd1);
            step();
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk("bp.full_noreq", 32'(imem_req), 32'd0);
            step();
        end
        chk("bp.head_pc", 32'(instr_pc), 32'd0);
        chk("bp.head", 32'(instr), 32'h12345);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        chk("bp.pop_head", 32'(instr_pc), 32'd1);
        chk("bp.pop_noreq", 32'(imem_req), 32'd0);
        step();
        chk("bp.refill_req", 32'(imem_req), 32'd1);
        chk("bp.refill_addr", 32'(imem_addr), 32'd4);
        imem_ack = 1'b1;
        imem_rdata = 19'h104;
        step();
        imem_ack = 1'b0;
        step();
        step();
        chk("bp.one_req_a", 32'(imem_req), 32'd0);
        step();
        chk("bp.one_req_b", 32'(imem_req), 32'd0);
        instr_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("bp.drain_pc", 32'(instr_pc), 32'(i));
            chk("bp.drain_data", 32'(instr), 32'h100 + 32'(i));
            step();
        end
        instr_ready = 1'b0;
        chk("bp.empty", 32'(instr_valid), 32'd0);
        chk("bp.req5", 32'(imem_req), 32'd1);
        chk("bp.addr5", 32'(imem_addr), 32'd5);

        // 4: flush while waiting, late ack discarded
        pcen_ref = pcen_n;
        flush = 1'b1;
        tgt = 19'h40;
        step();
        flush = 1'b0;
        chk("fw.drain_req", 32'(imem_req), 32'd1);
        chk("fw.drain_addr", 32'(imem_addr), 32'd5);
        chk("fw.valid", 32'(instr_valid), 32'd0);
        step();
        imem_ack = 1'b1;
        imem_rdata = 19'h7FFFF;
        step();
        imem_ack = 1'b0;
        chk_idle_outs("fw.after");
        step();
        chk("fw.redir_req", 32'(imem_req), 32'd1);
        chk("fw.redir_addr", 32'(imem_addr), 32'h40);
        chk("fw.valid2", 32'(instr_valid), 32'd0);
        chk("fw.no_pcen", 32'(pcen_n), 32'(pcen_ref));

        // 5a: flush coincident with ack
        imem_ack = 1'b1;
        imem_rdata = 19'h11111;
        flush = 1'b1;
        tgt = 19'h80;
        step();
        imem_ack = 1'b0;
        flush = 1'b0;
        chk_idle_outs("fa.after");
        step();
        chk("fa.addr", 32'(imem_addr), 32'h80);

        // 5b: flush during ADV
        imem_ack = 1'b1;
        imem_rdata = 19'h22222;
        step();
        imem_ack = 1'b0;
        chk("fadv.valid", 32'(instr_valid), 32'd1);
        chk("fadv.ipc", 32'(instr_pc), 32'h80);
        chk("fadv.pcen_pre", 32'(pc_enable), 32'd1);
        flush = 1'b1;
        tgt = 19'h100;
        #1;
        chk("fadv.pcen_kill", 32'(pc_enable), 32'd0);
        step();
        flush = 1'b0;
        chk_idle_outs("fadv.after");
        step();
        chk("fadv.req", 32'(imem_req), 32'd1);
        chk("fadv.addr", 32'(imem_addr), 32'h100);
        chk("fadv.no_pcen", 32'(pcen_n), 32'(pcen_ref));

        // 6: reset in REQ, then in DRAIN
        rst = 1'b1;
        step();
        chk_idle_outs("rreq");
        chk("rreq.addr", 32'(imem_addr), 32'd0);
        rst = 1'b0;
        step();
        chk("rreq.restart_req", 32'(imem_req), 32'd1);
        chk("rreq.restart_addr", 32'(imem_addr), 32'h100);
        flush = 1'b1;
        tgt = 19'h200;
        step();
        flush = 1'b0;
        chk("rdr.drain_addr", 32'(imem_addr), 32'h100);
        rst = 1'b1;
        step();
        chk_idle_outs("rdr");
        chk("rdr.addr", 32'(imem_addr), 32'd0);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 19'h33333;
        step();
        imem_ack = 1'b0;
        chk("rdr.stray_ack", 32'(instr_valid), 32'd0);
        chk("rdr.restart_req", 32'(imem_req), 32'd1);
        chk("rdr.restart_addr", 32'(imem_addr), 32'h200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
